// File: rtl/pwm_capture_peripheral.sv
// rtl/pwm_capture_peripheral.sv - bus-mapped PWM period/high-time capture block
//
// Measures the period and high time of pwm_in in clk cycles. The results are
// readable through a 32-byte register window at BASE_ADDR. When the build
// defines PWM_CAPTURE_DUTY_EN, a serial divider also computes the duty cycle
// in percent. Without that macro, DUTY reads 0.
//
// Ports:
//   clk, rst             clock; synchronous active-low reset
//   add, din, mask       byte address, write data, write byte enables
//   wr, rd               write / read requests
//   wr_busy, rd_busy     handshake busy flags
//   wr_strobe, rd_strobe master completion acknowledges
//   dout                 registered read data
//   pwm_in               asynchronous PWM signal under measurement
module pwm_capture_peripheral #(
  parameter logic [31:0] BASE_ADDR = 32'h4000_0100,
  parameter int          CNT_W     = 24
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] add,
  input  logic [31:0] din,
  output logic [31:0] dout,
  input  logic        wr,
  input  logic        rd,
  output logic        wr_busy,
  output logic        rd_busy,
  input  logic        wr_strobe,
  input  logic        rd_strobe,
  input  logic [3:0]  mask,
  input  logic        pwm_in
);

  typedef enum logic [1:0] {IDLE, WAIT_RISE, MEASURE} state_t;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t           state;
  logic             enable, valid, overflow;
  logic [CNT_W-1:0] cnt_p, cnt_h, period, high;
  logic [6:0]       duty;
  logic             sync1, synced, prev;
  logic [31:0]      rdata;

  // Two-flop synchronizer followed by a previous-level flop for edge detect
  always_ff @(posedge clk) begin
    if (!rst) begin
      sync1  <= 1'b0;
      synced <= 1'b0;
      prev   <= 1'b0;
    end else begin
      sync1  <= pwm_in;
      synced <= sync1;
      prev   <= synced;
    end
  end

  logic rise;
  assign rise = synced & ~prev;

  // The window is 32-byte aligned, so decode on the upper address bits
  logic       hit, wr_acc, rd_acc, ctrl_sel, status_sel;
  logic [2:0] off;
  assign hit        = (add[31:5] == BASE_ADDR[31:5]);
  assign off        = add[4:2];
  assign wr_acc     = wr & ~wr_busy & hit;
  assign rd_acc     = rd & ~rd_busy & hit;
  assign ctrl_sel   = (off == 3'd0);
  assign status_sel = (off == 3'd3);

  logic clr, w1c_valid, w1c_ovf, latch;
  assign clr       = wr_acc & ctrl_sel & mask[0] & din[0];
  assign w1c_valid = wr_acc & status_sel & mask[0] & din[0];
  assign w1c_ovf   = wr_acc & status_sel & mask[0] & din[1];
  // A clear in the same cycle suppresses the result latch
  assign latch     = enable & (state == MEASURE) & rise & ~clr;

  always_comb begin
    rdata = '0;
    case (off)
      3'd0: rdata[31]        = enable;
      3'd1: rdata[CNT_W-1:0] = period;
      3'd2: rdata[CNT_W-1:0] = high;
      3'd3: rdata[2:0]       = {synced, overflow, valid};
      3'd4: rdata[6:0]       = duty;
      default: rdata = '0;
    endcase
  end

  // Bus handshake and CTRL enable
  always_ff @(posedge clk) begin
    if (!rst) begin
      enable  <= 1'b0;
      wr_busy <= 1'b0;
      rd_busy <= 1'b0;
      dout    <= '0;
    end else begin
      if (wr_acc) begin
        wr_busy <= 1'b1;
        if (ctrl_sel && mask[3]) enable <= din[31];
      end else if (wr_busy && wr_strobe) begin
        wr_busy <= 1'b0;
      end
      if (rd_acc) begin
        rd_busy <= 1'b1;
        dout    <= rdata;
      end else if (rd_busy && rd_strobe) begin
        rd_busy <= 1'b0;
      end
    end
  end

  // Measurement FSM and result registers. The ordering makes a hardware set
  // win over W1C, and a clear win over everything.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= IDLE;
      cnt_p    <= '0;
      cnt_h    <= '0;
      period   <= '0;
      high     <= '0;
      valid    <= 1'b0;
      overflow <= 1'b0;
    end else begin
      if (w1c_valid) valid    <= 1'b0;
      if (w1c_ovf)   overflow <= 1'b0;
      if (!enable) begin
        state <= IDLE;
        cnt_p <= '0;
        cnt_h <= '0;
      end else begin
        case (state)
          IDLE: state <= WAIT_RISE;
          WAIT_RISE: begin
            if (rise) begin
              cnt_p <= CNT_W'(1);
              cnt_h <= CNT_W'(1);
              state <= MEASURE;
            end
          end
          MEASURE: begin
            if (rise) begin
              if (latch) begin
                period <= cnt_p;
                high   <= cnt_h;
                valid  <= 1'b1;
              end
              cnt_p <= CNT_W'(1);
              cnt_h <= CNT_W'(1);
            end else if (cnt_p == CNT_MAX) begin
              // Static input: give up and wait for a fresh edge
              overflow <= 1'b1;
              cnt_p    <= '0;
              cnt_h    <= '0;
              state    <= WAIT_RISE;
            end else begin
              // cnt_h never exceeds cnt_p, so only cnt_p needs the limit
              cnt_p <= cnt_p + CNT_W'(1);
              if (synced) cnt_h <= cnt_h + CNT_W'(1);
            end
          end
          default: state <= IDLE;
        endcase
      end
      if (clr) begin
        period   <= '0;
        high     <= '0;
        valid    <= 1'b0;
        overflow <= 1'b0;
      end
    end
  end

`ifdef PWM_CAPTURE_DUTY_EN
  // Restoring divider: (HIGH*100)/PERIOD, one quotient bit per cycle
  localparam int DW  = CNT_W + 7;
  localparam int DCW = $clog2(DW + 1);

  logic [DW-1:0]    quo, quo_nx;
  logic [CNT_W-1:0] rem, dvsr;
  logic [CNT_W:0]   rem_sh, rem_nx;
  logic [DCW-1:0]   dcnt;
  logic             dbusy, ge;

  assign rem_sh = {rem, quo[DW-1]};
  assign ge     = (rem_sh >= {1'b0, dvsr});
  assign rem_nx = ge ? (rem_sh - {1'b0, dvsr}) : rem_sh;
  assign quo_nx = {quo[DW-2:0], ge};

  always_ff @(posedge clk) begin
    if (!rst) begin
      quo   <= '0;
      rem   <= '0;
      dvsr  <= '0;
      dcnt  <= '0;
      dbusy <= 1'b0;
      duty  <= '0;
    end else if (clr) begin
      dbusy <= 1'b0;
      duty  <= '0;
    end else if (latch) begin
      dvsr  <= cnt_p;
      quo   <= DW'(cnt_h) * DW'(100);
      rem   <= '0;
      dcnt  <= DCW'(DW);
      dbusy <= 1'b1;
    end else if (dbusy) begin
      quo  <= quo_nx;
      rem  <= rem_nx[CNT_W-1:0];
      dcnt <= dcnt - DCW'(1);
      if (dcnt == DCW'(1)) begin
        dbusy <= 1'b0;
        duty  <= (quo_nx > DW'(100)) ? 7'd100 : quo_nx[6:0];
      end
    end
  end

  logic unused_div;
  assign unused_div = &{1'b0, rem_nx[CNT_W]};
`else
  assign duty = '0;
`endif

  logic unused_bits;
  assign unused_bits = &{1'b0, din[30:2], mask[2:1], add[1:0]};

endmodule

// File: tb/tb_pwm_capture_peripheral.sv
// tb/tb_pwm_capture_peripheral.sv - directed self-checking bench for pwm_capture_peripheral
module tb_pwm_capture_peripheral;

  localparam logic [31:0] BASE = 32'h4000_0100;
  localparam logic [31:0] CTRL = BASE + 32'h00;
  localparam logic [31:0] PER  = BASE + 32'h04;
  localparam logic [31:0] HIGH = BASE + 32'h08;
  localparam logic [31:0] STAT = BASE + 32'h0C;
  localparam logic [31:0] DUTY = BASE + 32'h10;
`ifdef PWM_CAPTURE_DUTY_EN
  localparam bit DUTY_ON = 1'b1;
`else
  localparam bit DUTY_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] add = '0;
  logic [31:0] din = '0;
  logic [31:0] dout;
  logic        wr = 1'b0, rd = 1'b0;
  logic        wr_busy, rd_busy;
  logic        wr_strobe = 1'b0, rd_strobe = 1'b0;
  logic [3:0]  mask = '0;
  logic        pwm_in;

  pwm_capture_peripheral #(.BASE_ADDR(BASE), .CNT_W(10)) dut (
    .clk(clk), .rst(rst), .add(add), .din(din), .dout(dout),
    .wr(wr), .rd(rd), .wr_busy(wr_busy), .rd_busy(rd_busy),
    .wr_strobe(wr_strobe), .rd_strobe(rd_strobe), .mask(mask),
    .pwm_in(pwm_in)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // PWM generator: picks up new settings only at a period boundary
  int gen_period = 100;
  int gen_high   = 40;
  bit gen_run    = 1'b0;
  bit gen_hold   = 1'b0;

  initial begin
    pwm_in = 1'b0;
    forever begin
      if (gen_run) begin
        int p, h;
        p = gen_period;
        h = gen_high;
        for (int i = 0; i < p; i++) begin
          @(negedge clk);
          pwm_in = (i < h);
        end
      end else begin
        @(negedge clk);
        pwm_in = gen_hold;
      end
    end
  end

  logic        wbusy_seen, rbusy_seen;
  logic [31:0] rdat;

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] m);
    @(negedge clk);
    add = a; din = d; mask = m; wr = 1'b1;
    @(negedge clk);
    wr = 1'b0;
    wbusy_seen = wr_busy;
    wr_strobe = 1'b1;
    @(negedge clk);
    wr_strobe = 1'b0;
    @(negedge clk);
  endtask

  task automatic bus_read(input logic [31:0] a);
    @(negedge clk);
    add = a; rd = 1'b1;
    @(negedge clk);
    rd = 1'b0;
    rdat = dout;
    rbusy_seen = rd_busy;
    rd_strobe = 1'b1;
    @(negedge clk);
    rd_strobe = 1'b0;
    @(negedge clk);
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    // Reset state
    wait_cycles(3);
    rst = 1'b1;
    @(negedge clk);
    check("reset wr_busy", {31'b0, wr_busy}, 32'h0);
    check("reset rd_busy", {31'b0, rd_busy}, 32'h0);
    check("reset dout", dout, 32'h0);
    bus_read(CTRL); check("reset CTRL", rdat, 32'h0);
    check("rd_busy asserted", {31'b0, rbusy_seen}, 32'h1);
    check("rd_busy released", {31'b0, rd_busy}, 32'h0);
    bus_read(PER);  check("reset PERIOD", rdat, 32'h0);
    bus_read(HIGH); check("reset HIGH", rdat, 32'h0);
    bus_read(STAT); check("reset STATUS", rdat, 32'h0);
    bus_read(DUTY); check("reset DUTY", rdat, 32'h0);

    // 1000/250 measurement
    bus_write(CTRL, 32'h8000_0000, 4'hF);
    check("wr_busy asserted", {31'b0, wbusy_seen}, 32'h1);
    check("wr_busy released", {31'b0, wr_busy}, 32'h0);
    gen_period = 1000; gen_high = 250; gen_run = 1'b1;
    wait_cycles(2600);
    bus_read(CTRL); check("CTRL enable", rdat, 32'h8000_0000);
    bus_read(PER);  check("PERIOD 1000", rdat, 32'd1000);
    bus_read(HIGH); check("HIGH 250", rdat, 32'd250);
    bus_read(STAT); check("STATUS valid", rdat & 32'h3, 32'h1);
    bus_read(DUTY); check("DUTY 25", rdat, DUTY_ON ? 32'd25 : 32'd0);

    // Switch to 200/150
    gen_period = 200; gen_high = 150;
    wait_cycles(1600);
    bus_read(PER);  check("PERIOD 200", rdat, 32'd200);
    bus_read(HIGH); check("HIGH 150", rdat, 32'd150);
    bus_read(DUTY); check("DUTY 75", rdat, DUTY_ON ? 32'd75 : 32'd0);

    // Out-of-window accesses: no busy, no effect, dout untouched
    bus_read(PER);
    bus_read(BASE + 32'h20);
    check("oor rd_busy", {31'b0, rbusy_seen}, 32'h0);
    check("oor dout held", rdat, 32'd200);
    bus_write(BASE + 32'h20, 32'h0, 4'hF);
    check("oor wr_busy", {31'b0, wbusy_seen}, 32'h0);
    bus_read(CTRL); check("oor CTRL intact", rdat, 32'h8000_0000);

    // Static high input -> overflow, results retained
    gen_hold = 1'b1; gen_run = 1'b0;
    wait_cycles(1500);
    bus_read(STAT); check("STATUS overflow", rdat, 32'h7);
    bus_read(PER);  check("ovf PERIOD kept", rdat, 32'd200);
    bus_read(HIGH); check("ovf HIGH kept", rdat, 32'd150);
    bus_write(STAT, 32'h3, 4'hF);
    bus_read(STAT); check("STATUS W1C", rdat, 32'h4);

    // Disable, clear, then masked enable write must not enable
    bus_write(CTRL, 32'h0, 4'hF);
    bus_write(CTRL, 32'h1, 4'hF);
    bus_read(PER);  check("clear PERIOD", rdat, 32'h0);
    bus_read(CTRL); check("CTRL bit0 reads 0", rdat, 32'h0);
    bus_write(CTRL, 32'h8000_0000, 4'b0111);
    gen_period = 100; gen_high = 40; gen_run = 1'b1;
    wait_cycles(400);
    bus_read(CTRL); check("masked CTRL", rdat, 32'h0);
    bus_read(PER);  check("masked no PERIOD", rdat, 32'h0);
    bus_read(STAT); check("masked no valid", rdat & 32'h3, 32'h0);

    // Reset mid-measurement
    bus_write(CTRL, 32'h8000_0000, 4'hF);
    wait_cycles(350);
    @(negedge clk); rst = 1'b0;
    @(negedge clk); rst = 1'b1;
    gen_run = 1'b0; gen_hold = 1'b0;
    wait_cycles(200);
    bus_read(CTRL); check("post-rst CTRL", rdat, 32'h0);
    bus_read(PER);  check("post-rst PERIOD", rdat, 32'h0);
    bus_read(HIGH); check("post-rst HIGH", rdat, 32'h0);
    bus_read(STAT); check("post-rst STATUS", rdat, 32'h0);
    bus_read(DUTY); check("post-rst DUTY", rdat, 32'h0);
    bus_write(CTRL, 32'h8000_0000, 4'hF);
    gen_run = 1'b1;
    wait_cycles(60);
    bus_read(STAT); check("one edge no valid", rdat, 32'h0);
    wait_cycles(100);
    bus_read(PER);  check("re-run PERIOD", rdat, 32'd100);
    bus_read(HIGH); check("re-run HIGH", rdat, 32'd40);
    bus_read(STAT); check("re-run valid", rdat & 32'h1, 32'h1);
    bus_read(DUTY); check("re-run DUTY", rdat, DUTY_ON ? 32'd40 : 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
